// File: rtl/clock_time_controller.sv
// Mode/edit FSM for the 24-hour clock: time-set, alarm-set, load strobe and alarm ring.
// Buttons act one cycle after sampling; no backpressure (pulse inputs, strobe outputs).
module clock_time_controller #(
   parameter int ALARM_HR_INIT  = 6,
   parameter int ALARM_MIN_INIT = 0,
   parameter int RING_SECS      = 60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_alarm_off,
   input  logic [4:0] cur_hr,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic       clk_en,
   output logic       load,
   output logic [4:0] ld_hr,
   output logic [5:0] ld_min,
   output logic [5:0] ld_sec,
   output logic [1:0] edit_field,
   output logic       alm_sel,
   output logic       blink,
   output logic [4:0] alarm_hr,
   output logic [5:0] alarm_min,
   output logic       armed,
   output logic       alarm_ring
);

   typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, ALM_HR, ALM_MIN} state_t;

   state_t     state, state_nxt;
   logic       inc_ok, armed_nxt, blink_nxt;
   logic       match, match_d, ring_set, ring_clr;
   logic [5:0] ring_cnt;

   function automatic logic [4:0] inc_hr(input logic [4:0] v);
      return (v >= 5'd23) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [5:0] inc_min(input logic [5:0] v);
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   always_comb begin
      state_nxt = state;
      if (btn_mode) begin
         case (state)
            RUN:     state_nxt = SET_HR;
            SET_HR:  state_nxt = SET_MIN;
            SET_MIN: state_nxt = ALM_HR;
            ALM_HR:  state_nxt = ALM_MIN;
            default: state_nxt = RUN;
         endcase
      end
   end

   // Mode takes priority over inc when both arrive together.
   assign inc_ok    = btn_inc & ~btn_mode;
   assign armed_nxt = (inc_ok && state == RUN) ? ~armed : armed;

   always_comb begin
      blink_nxt = blink;
      if (state_nxt == RUN || state_nxt != state) blink_nxt = 1'b0;
      else if (tick)                              blink_nxt = ~blink;
   end

   always_comb begin
      edit_field = 2'd0;
      case (state)
         SET_HR:          edit_field = 2'd1;
         SET_MIN:         edit_field = 2'd2;
         ALM_HR, ALM_MIN: edit_field = 2'd3;
         default:         edit_field = 2'd0;
      endcase
   end

   assign alm_sel = (state == ALM_MIN);
   assign ld_sec  = 6'd0;
   // Time is frozen while editing, and never advances in the load cycle.
   assign clk_en  = tick & ~reset & ~load &
                    (state == RUN || state == ALM_HR || state == ALM_MIN);

   assign match    = armed && state != SET_HR && state != SET_MIN &&
                     cur_hr == alarm_hr && cur_min == alarm_min && cur_sec == 6'd0;
   assign ring_set = match & ~match_d;
   assign ring_clr = btn_alarm_off | ~armed_nxt |
                     (alarm_ring & tick & (ring_cnt == 6'(RING_SECS - 1)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RUN;
         load       <= 1'b0;
         ld_hr      <= 5'd0;
         ld_min     <= 6'd0;
         blink      <= 1'b0;
         alarm_hr   <= 5'(ALARM_HR_INIT);
         alarm_min  <= 6'(ALARM_MIN_INIT);
         armed      <= 1'b0;
         match_d    <= 1'b0;
         alarm_ring <= 1'b0;
         ring_cnt   <= 6'd0;
      end else begin
         state   <= state_nxt;
         load    <= btn_mode && state == SET_MIN;
         blink   <= blink_nxt;
         armed   <= armed_nxt;
         match_d <= match;

         if (btn_mode && state == RUN) begin
            ld_hr  <= cur_hr;
            ld_min <= cur_min;
         end else if (inc_ok && state == SET_HR) begin
            ld_hr <= inc_hr(ld_hr);
         end else if (inc_ok && state == SET_MIN) begin
            ld_min <= inc_min(ld_min);
         end

         if (inc_ok && state == ALM_HR)  alarm_hr  <= inc_hr(alarm_hr);
         if (inc_ok && state == ALM_MIN) alarm_min <= inc_min(alarm_min);

         if (ring_clr) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= 6'd0;
         end else if (ring_set) begin
            alarm_ring <= 1'b1;
            ring_cnt   <= 6'd0;
         end else if (alarm_ring && tick) begin
            ring_cnt <= ring_cnt + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed table-driven bench for clock_time_controller: edit flow, load strobe, alarm ring/clear.
module tb_clock_time_controller;

   logic       clock = 1'b0;
   logic       reset, tick, btn_mode, btn_inc, btn_alarm_off;
   logic [4:0] cur_hr;
   logic [5:0] cur_min, cur_sec;
   logic       clk_en, load, alm_sel, blink, armed, alarm_ring;
   logic [4:0] ld_hr, alarm_hr;
   logic [5:0] ld_min, ld_sec, alarm_min;
   logic [1:0] edit_field;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   clock_time_controller #(.ALARM_HR_INIT(6), .ALARM_MIN_INIT(0), .RING_SECS(60)) dut (
      .clock(clock), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .btn_alarm_off(btn_alarm_off), .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
      .clk_en(clk_en), .load(load), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
      .edit_field(edit_field), .alm_sel(alm_sel), .blink(blink), .alarm_hr(alarm_hr),
      .alarm_min(alarm_min), .armed(armed), .alarm_ring(alarm_ring)
   );

   typedef struct {
      logic m, i, o, t;
      int   h, mi, s, rep;
      logic en, ld;
      int   f;
      logic as, bl;
      int   lh, lm, ah, am;
      logic arm, ring;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic m, logic i, logic o, logic t, int h, int mi, int s, int rep,
                               logic en, logic ld, int f, logic as, logic bl,
                               int lh, int lm, int ah, int am, logic arm, logic ring);
      vec_t v;
      v.m = m; v.i = i; v.o = o; v.t = t; v.h = h; v.mi = mi; v.s = s; v.rep = rep;
      v.en = en; v.ld = ld; v.f = f; v.as = as; v.bl = bl;
      v.lh = lh; v.lm = lm; v.ah = ah; v.am = am; v.arm = arm; v.ring = ring;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic m, input logic i, input logic o, input logic t,
                        input int h, input int mi, input int s);
      btn_mode = m; btn_inc = i; btn_alarm_off = o; tick = t;
      cur_hr = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
   endtask

   task automatic check_regs(input string tag, input vec_t v);
      chk({tag, " load"},       int'(load),       int'(v.ld));
      chk({tag, " edit_field"}, int'(edit_field), v.f);
      chk({tag, " alm_sel"},    int'(alm_sel),    int'(v.as));
      chk({tag, " blink"},      int'(blink),      int'(v.bl));
      chk({tag, " ld_hr"},      int'(ld_hr),      v.lh);
      chk({tag, " ld_min"},     int'(ld_min),     v.lm);
      chk({tag, " ld_sec"},     int'(ld_sec),     0);
      chk({tag, " alarm_hr"},   int'(alarm_hr),   v.ah);
      chk({tag, " alarm_min"},  int'(alarm_min),  v.am);
      chk({tag, " armed"},      int'(armed),      int'(v.arm));
      chk({tag, " alarm_ring"}, int'(alarm_ring), int'(v.ring));
   endtask

   initial begin
      //           m i o t  hr mi  s rep  en ld f as bl  lh lm ah am arm ring
      vecs.push_back(mk(0,0,0,1, 10,20, 5, 3,  1,0,0,0,0,  0, 0, 6, 0, 0,0)); // RUN ticks
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,1,0,0, 10,20, 6, 0, 0,0)); // enter SET_HR
      vecs.push_back(mk(0,0,0,1, 10,20, 5, 1,  0,0,1,0,1, 10,20, 6, 0, 0,0)); // frozen, blink
      vecs.push_back(mk(0,1,0,0, 10,20, 5,15,  0,0,1,0,1,  1,20, 6, 0, 0,0)); // hr wraps 23->0
      vecs.push_back(mk(1,1,0,0, 10,20, 5, 1,  0,0,2,0,0,  1,20, 6, 0, 0,0)); // mode beats inc
      vecs.push_back(mk(0,0,0,1, 10,20, 5, 1,  0,0,2,0,1,  1,20, 6, 0, 0,0));
      vecs.push_back(mk(0,1,0,0, 10,20, 5,45,  0,0,2,0,1,  1, 5, 6, 0, 0,0)); // min wraps 59->0
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,1,3,0,0,  1, 5, 6, 0, 0,0)); // load strobe
      vecs.push_back(mk(0,0,0,1, 10,20, 5, 1,  0,0,3,0,1,  1, 5, 6, 0, 0,0)); // tick in load cycle
      vecs.push_back(mk(0,0,0,1, 10,20, 5, 1,  1,0,3,0,0,  1, 5, 6, 0, 0,0));
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,3,1,0,  1, 5, 6, 0, 0,0)); // ALM_MIN
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,0,0,0,  1, 5, 6, 0, 0,0)); // back to RUN
      vecs.push_back(mk(0,1,0,0, 10,20, 5, 1,  0,0,0,0,0,  1, 5, 6, 0, 1,0)); // arm
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,1,0,0, 10,20, 6, 0, 1,0));
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,2,0,0, 10,20, 6, 0, 1,0));
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,1,3,0,0, 10,20, 6, 0, 1,0));
      vecs.push_back(mk(0,1,0,0, 10,20, 5, 1,  0,0,3,0,0, 10,20, 7, 0, 1,0)); // alarm hr 7
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,3,1,0, 10,20, 7, 0, 1,0));
      vecs.push_back(mk(0,1,0,0, 10,20, 5,30,  0,0,3,1,0, 10,20, 7,30, 1,0)); // alarm min 30
      vecs.push_back(mk(1,0,0,0, 10,20, 5, 1,  0,0,0,0,0, 10,20, 7,30, 1,0));
      vecs.push_back(mk(0,0,0,0,  7,30,59, 1,  0,0,0,0,0, 10,20, 7,30, 1,0));
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 1,1)); // ring rises
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 3,  0,0,0,0,0, 10,20, 7,30, 1,1)); // held
      vecs.push_back(mk(0,0,1,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 1,0)); // alarm off
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 2,  0,0,0,0,0, 10,20, 7,30, 1,0)); // no retrigger
      vecs.push_back(mk(0,0,0,0,  7,30, 1, 1,  0,0,0,0,0, 10,20, 7,30, 1,0));
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 1,1));
      vecs.push_back(mk(0,0,0,1,  7,30, 1,59,  1,0,0,0,0, 10,20, 7,30, 1,1)); // 59 ticks ringing
      vecs.push_back(mk(0,0,0,1,  7,30, 1, 1,  1,0,0,0,0, 10,20, 7,30, 1,0)); // 60th clears
      vecs.push_back(mk(0,0,0,0,  7,30, 2, 1,  0,0,0,0,0, 10,20, 7,30, 1,0));
      vecs.push_back(mk(0,0,1,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 1,0)); // set+off: clear
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 1,0));
      vecs.push_back(mk(0,0,0,0,  7,30, 2, 1,  0,0,0,0,0, 10,20, 7,30, 1,0));
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 1,1));
      vecs.push_back(mk(0,1,0,0,  7,30, 0, 1,  0,0,0,0,0, 10,20, 7,30, 0,0)); // disarm clears
      vecs.push_back(mk(0,0,0,0,  7,30, 0, 2,  0,0,0,0,0, 10,20, 7,30, 0,0));

      reset = 1'b1;
      drive(0, 0, 0, 1, 10, 20, 5);
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset clk_en", int'(clk_en), 0);
      reset = 1'b0;
      tick = 1'b0;
      @(posedge clock); #1;
      check_regs("reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,6,0, 0,0));

      foreach (vecs[k]) begin
         for (int r = 0; r < vecs[k].rep; r++) begin
            @(negedge clock);
            drive(vecs[k].m, vecs[k].i, vecs[k].o, vecs[k].t, vecs[k].h, vecs[k].mi, vecs[k].s);
            #1;
            chk($sformatf("v%0d clk_en", k), int'(clk_en), int'(vecs[k].en));
            @(posedge clock); #1;
         end
         check_regs($sformatf("v%0d", k), vecs[k]);
      end

      // Reset in SET_MIN after edits: the pending mode press must not produce a load.
      @(negedge clock); drive(1, 0, 0, 0, 10, 20, 5);
      @(negedge clock); drive(0, 1, 0, 0, 10, 20, 5);
      @(negedge clock); drive(0, 1, 0, 0, 10, 20, 5);
      @(negedge clock); drive(1, 0, 0, 0, 10, 20, 5);
      @(negedge clock); drive(0, 1, 0, 0, 10, 20, 5);
      @(posedge clock); #1;
      chk("pre-reset ld_hr", int'(ld_hr), 12);
      chk("pre-reset ld_min", int'(ld_min), 21);
      chk("pre-reset field", int'(edit_field), 2);
      @(negedge clock);
      drive(1, 0, 0, 1, 10, 20, 5);
      reset = 1'b1;
      #1;
      chk("mid-edit reset clk_en", int'(clk_en), 0);
      @(posedge clock); #1;
      check_regs("mid-edit reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,6,0, 0,0));
      @(negedge clock);
      reset = 1'b0;
      drive(0, 0, 0, 0, 10, 20, 5);
      @(posedge clock); #1;
      chk("post-reset load", int'(load), 0);
      chk("post-reset field", int'(edit_field), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
